// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with a valid/ready handshake.
// The shift distance is decomposed into log2(WIDTH) mux levels, where level j
// shifts by 2^j. The levels are spread across STAGES register banks. The last
// bank drives the outputs directly. Supported operations are logical,
// arithmetic and rotate shifts. The unit also returns the last bit shifted out
// and a zero flag, and carries a sideband tag through unchanged.
module pipelined_barrel_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  localparam int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SAW-1:0]   sa,
  input  logic [2:0]       shift_op,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_carry,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag
);

  localparam int SW = SAW;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b110;
  localparam logic [2:0] OP_ROL = 3'b111;

  // One pipeline slot. The full shift amount travels with the operation.
  // Each level looks only at its own bit of that amount.
  // fill is the sign bit used by SRA. carry is the last bit shifted out so far.
  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [2:0]       op;
    logic [SAW-1:0]   sa;
    logic             fill;
    logic             carry;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stg_src [STAGES];
  stage_t stg_d   [STAGES];
  stage_t stg_q   [STAGES];
  logic   zero_d;
  logic   zero_q;
  logic   adv;

  // The whole pipeline moves together. It stalls only when a result is held
  // at the output and the consumer is not taking it.
  assign adv     = !stg_q[STAGES-1].vld || o_ready;
  assign i_ready = adv && !rst;

  // Applies mux level lvl, which shifts by 2^lvl when bit lvl of sa is set.
  // Only the last level that actually shifts decides the carry. Its
  // outgoing bit is the same bit that the one-step shift by sa would
  // report.
  function automatic stage_t apply_level(input stage_t cur, input int lvl);
    stage_t           nxt;
    logic [SAW-1:0]   sa_sh;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] fill_mask;
    int               amt;
    nxt       = cur;
    amt       = 1 << lvl;
    sa_sh     = cur.sa >> lvl;
    // bit 0 of lo_out is the last bit leaving the low end on a right shift
    lo_out    = cur.data >> (amt - 1);
    // hi_out holds the bits leaving the top. Its bit 0 is the last one to leave.
    hi_out    = cur.data >> (WIDTH - amt);
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    if (sa_sh[0]) begin
      case (cur.op)
        OP_SLL: begin
          nxt.data  = cur.data << amt;
          nxt.carry = hi_out[0];
        end
        OP_SRL: begin
          nxt.data  = cur.data >> amt;
          nxt.carry = lo_out[0];
        end
        OP_SRA: begin
          nxt.data  = (cur.data >> amt) | (cur.fill ? fill_mask : '0);
          nxt.carry = lo_out[0];
        end
        OP_ROR: begin
          nxt.data  = (cur.data >> amt) | (cur.data << (WIDTH - amt));
          nxt.carry = lo_out[0];
        end
        OP_ROL: begin
          nxt.data  = (cur.data << amt) | hi_out;
          nxt.carry = hi_out[0];
        end
        default: ;
      endcase
    end
    return nxt;
  endfunction

  // Per-stage combinational shift. The input is loaded into stage 0 and each
  // later stage reads the bank before it. Level j goes to stage
  // floor(j*STAGES/SW). When not advancing, the banks hold.
  always_comb begin
    stage_t cur;
    cur = '0;
    stg_src[0].vld   = i_valid;
    stg_src[0].tag   = i_tag;
    stg_src[0].op    = shift_op;
    stg_src[0].sa    = sa;
    stg_src[0].fill  = i_data[WIDTH-1];
    stg_src[0].carry = 1'b0;
    stg_src[0].data  = i_data;
    for (int s = 1; s < STAGES; s++) begin
      stg_src[s] = stg_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      cur = stg_src[s];
      for (int j = 0; j < SW; j++) begin
        if ((j * STAGES) / SW == s) begin
          cur = apply_level(cur, j);
        end
      end
      stg_d[s] = adv ? cur : stg_q[s];
    end
    zero_d = (stg_d[STAGES-1].data == '0);
  end

  // Stage registers and the zero flag, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= '0;
      end
      zero_q <= 1'b0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        stg_q[s] <= stg_d[s];
      end
      zero_q <= zero_d;
    end
  end

  assign o_valid = stg_q[STAGES-1].vld;
  assign o_data  = stg_q[STAGES-1].data;
  assign o_carry = stg_q[STAGES-1].carry;
  assign o_zero  = zero_q;
  assign o_tag   = stg_q[STAGES-1].tag;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter with WIDTH=32, STAGES=2.
// The stimulus side pushes the expected results when an operation is accepted.
// The monitor pops and compares them whenever a result is handed over.
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic [4:0]  sa;
  logic [2:0]  shift_op;
  logic [3:0]  i_tag;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_carry;
  logic        o_zero;
  logic [3:0]  o_tag;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .sa(sa),
    .shift_op(shift_op), .i_tag(i_tag),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_carry(o_carry), .o_zero(o_zero), .o_tag(o_tag)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        z;
    logic [3:0]  t;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  s;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ec;
  } vec_t;

  // hand-computed directed vectors: op, sa, data, expected data, expected carry
  localparam vec_t VECS [20] = '{
    '{3'b001, 5'd1,  32'h80000001, 32'h00000002, 1'b1},
    '{3'b100, 5'd31, 32'h80000000, 32'hFFFFFFFF, 1'b0},
    '{3'b010, 5'd31, 32'h80000000, 32'h00000001, 1'b0},
    '{3'b110, 5'd4,  32'h00000001, 32'h10000000, 1'b0},
    '{3'b111, 5'd1,  32'h80000000, 32'h00000001, 1'b1},
    '{3'b011, 5'd5,  32'h12345678, 32'h12345678, 1'b0},
    '{3'b001, 5'd0,  32'h12345678, 32'h12345678, 1'b0},
    '{3'b010, 5'd1,  32'h00000001, 32'h00000000, 1'b1},
    '{3'b100, 5'd4,  32'hF0000000, 32'hFF000000, 1'b0},
    '{3'b010, 5'd5,  32'h000000F0, 32'h00000007, 1'b1},
    '{3'b001, 5'd31, 32'h0000000F, 32'h80000000, 1'b1},
    '{3'b110, 5'd8,  32'h12345678, 32'h78123456, 1'b0},
    '{3'b111, 5'd4,  32'h12345678, 32'h23456781, 1'b1},
    '{3'b110, 5'd31, 32'h80000001, 32'h00000003, 1'b0},
    '{3'b111, 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1},
    '{3'b000, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0},
    '{3'b101, 5'd3,  32'h00000000, 32'h00000000, 1'b0},
    '{3'b100, 5'd16, 32'h7FFFFFFF, 32'h00007FFF, 1'b1},
    '{3'b001, 5'd16, 32'hA5A5A5A5, 32'hA5A50000, 1'b1},
    '{3'b110, 5'd13, 32'h00000000, 32'h00000000, 1'b0}
  };

  exp_t sb_q [$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: random, 3: never

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // single-cycle reference definition used for the random vectors
  task automatic golden(input logic [2:0] op, input logic [4:0] s, input logic [31:0] d,
                        output logic [31:0] ed, output logic ec);
    logic [31:0] t;
    int n;
    n  = int'(s);
    ed = d;
    ec = 1'b0;
    case (op)
      3'b001: begin ed = d << n; t = d >> (32 - n); ec = (n != 0) && t[0]; end
      3'b010: begin ed = d >> n; if (n != 0) begin t = d >> (n - 1); ec = t[0]; end end
      3'b100: begin ed = 32'($signed(d) >>> n); if (n != 0) begin t = d >> (n - 1); ec = t[0]; end end
      3'b110: begin ed = (d >> n) | (d << (32 - n)); ec = (n != 0) && ed[31]; end
      3'b111: begin ed = (d << n) | (d >> (32 - n)); ec = (n != 0) && ed[0]; end
      default: ;
    endcase
  endtask

  // offer one operation; push its expectation once acceptance is certain
  task automatic send(input logic [2:0] op, input logic [4:0] s, input logic [31:0] d,
                      input logic [3:0] t, input logic [31:0] ed, input logic ec);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    i_valid = 1'b1; shift_op = op; sa = s; i_data = d; i_tag = t;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (i_ready) ok = 1'b1;
      n++;
    end
    if (ok) sb_q.push_back('{d: ed, c: ec, z: (ed == 32'h0), t: t});
    else begin
      checks++; errors++;
      $display("FAIL accept_timeout tag %0d got no i_ready within 200 cycles want i_ready", t);
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // consumer ready generator
  initial begin
    int k;
    k = 0;
    o_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: o_ready = 1'b1;
        1: begin o_ready = (k % 3 == 0); k++; end
        2: o_ready = 1'($urandom_range(0, 1));
        default: o_ready = 1'b0;
      endcase
    end
  end

  // monitor: handshake rule, output hold while stalled, scoreboard compare
  initial begin
    logic        stalled_prev;
    logic [38:0] held;
    exp_t        e;
    stalled_prev = 1'b0;
    held = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (i_ready !== ((!o_valid || o_ready) && !rst)) begin
        errors++;
        $display("FAIL i_ready got %b want %b", i_ready, (!o_valid || o_ready) && !rst);
      end
      if (stalled_prev) begin
        checks++;
        if ({o_valid, o_data, o_carry, o_zero, o_tag} !== held) begin
          errors++;
          $display("FAIL hold got %h want %h", {o_valid, o_data, o_carry, o_zero, o_tag}, held);
        end
      end
      stalled_prev = o_valid && !o_ready && !rst;
      held = {o_valid, o_data, o_carry, o_zero, o_tag};
      if (o_valid && o_ready && !rst) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got tag %0d data %h want no result", o_tag, o_data);
        end else begin
          e = sb_q.pop_front();
          if ({o_data, o_carry, o_zero, o_tag} !== e) begin
            errors++;
            $display("FAIL result got data=%h c=%b z=%b tag=%0d want data=%h c=%b z=%b tag=%0d",
                     o_data, o_carry, o_zero, o_tag, e.d, e.c, e.z, e.t);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    int          n;
    logic [2:0]  rop;
    logic [4:0]  rs;
    logic [31:0] rd;
    logic [31:0] ed;
    logic        ec;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; sa = '0; shift_op = '0; i_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data",  o_data, 0);
    chk("rst_o_carry", 32'(o_carry), 0);
    chk("rst_o_zero",  32'(o_zero), 0);
    chk("rst_o_tag",   32'(o_tag), 0);

    // the acceptance edge counts as the first of the STAGES edges
    send(VECS[0].op, VECS[0].s, VECS[0].d, 4'd0, VECS[0].ed, VECS[0].ec);
    n = 1;
    while (!o_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 2);
    for (int i = 1; i < 6; i++)
      send(VECS[i].op, VECS[i].s, VECS[i].d, 4'(i), VECS[i].ed, VECS[i].ec);
    drain("drain_directed");

    // back-to-back stream, tags 0..7, ready pattern 1,0,0
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(VECS[6+i].op, VECS[6+i].s, VECS[6+i].d, 4'(i), VECS[6+i].ed, VECS[6+i].ec);
    rdy_mode = 2;
    for (int i = 14; i < 20; i++)
      send(VECS[i].op, VECS[i].s, VECS[i].d, 4'(i - 6), VECS[i].ed, VECS[i].ec);
    rdy_mode = 0;
    drain("drain_stream");

    // reset with two operations in flight; neither may ever be delivered
    rdy_mode = 3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_valid = 1'b1; shift_op = 3'b001; sa = 5'd3; i_data = 32'h0000_00FF; i_tag = 4'd14;
    @(negedge clk);
    chk("inflight_a_ready", 32'(i_ready), 1);
    @(posedge clk); #1;
    shift_op = 3'b010; sa = 5'd2; i_data = 32'hF000_0000; i_tag = 4'd15;
    @(negedge clk);
    chk("inflight_b_ready", 32'(i_ready), 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy_mode = 0;
    chk("mid_rst_o_valid", 32'(o_valid), 0);
    chk("mid_rst_o_data",  o_data, 0);
    chk("mid_rst_o_carry", 32'(o_carry), 0);
    chk("mid_rst_o_zero",  32'(o_zero), 0);
    chk("mid_rst_o_tag",   32'(o_tag), 0);
    repeat (8) @(posedge clk);
    #1;

    // random operands against the reference, random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rs  = 5'($urandom_range(0, 31));
      rd  = $urandom;
      golden(rop, rs, rd, ed, ec);
      send(rop, rs, rd, 4'(i), ed, ec);
    end
    rdy_mode = 0;
    drain("drain_random");
    repeat (4) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
